// File: rtl/vmem_console_writer.sv
// vmem_console_writer: byte stream to text-console writes on the vmem write port (clk, rst, in_data/in_valid/in_ready in; vmem_addr/vmem_data/vmem_we, cur_col/cur_row, busy out)
module vmem_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int BASE = 0,
  parameter logic [7:0] FILL = 8'h20,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] vmem_addr,
  output logic [7:0]  vmem_data,
  output logic        vmem_we,
  output logic [6:0]  cur_col,
  output logic [5:0]  cur_row,
  output logic        busy
);
  localparam logic [12:0] B = 13'(BASE);
  localparam logic [12:0] LAST = 13'(BASE + COLS * ROWS - 1);
  localparam logic [12:0] C = 13'(COLS);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [12:0] addr_n, clr, clr_n, row_base, row_base_n;
  logic [7:0] data_n;
  logic we_n, ready_n, busy_n, last_row;
  logic [6:0] col_n;
  logic [5:0] row_n;
  assign last_row = cur_row == ROW_MAX;
  // clr holds the next address the fill walk will write; row_base tracks BASE + row*COLS
  always_comb begin
    state_n = state;
    addr_n = vmem_addr;
    data_n = vmem_data;
    we_n = 1'b0;
    ready_n = 1'b0;
    busy_n = 1'b0;
    col_n = cur_col;
    row_n = cur_row;
    clr_n = clr;
    row_base_n = row_base;
    if (state == CLEAR) begin
      we_n = 1'b1;
      busy_n = 1'b1;
      addr_n = clr;
      data_n = FILL;
      clr_n = clr + 13'd1;
      state_n = clr == LAST ? IDLE : CLEAR;
    end else begin
      ready_n = 1'b1;
      if (in_valid && in_ready) begin
        case (in_data)
          8'h0D: col_n = 7'd0;
          8'h0A: begin
            row_n = last_row ? 6'd0 : cur_row + 6'd1;
            row_base_n = last_row ? B : row_base + C;
          end
          8'h08: col_n = cur_col == 7'd0 ? 7'd0 : cur_col - 7'd1;
          // form feed issues the first fill write itself so busy lines up with the writes
          8'h0C: begin
            ready_n = 1'b0;
            busy_n = 1'b1;
            we_n = 1'b1;
            addr_n = B;
            data_n = FILL;
            clr_n = B + 13'd1;
            col_n = 7'd0;
            row_n = 6'd0;
            row_base_n = B;
            state_n = B == LAST ? IDLE : CLEAR;
          end
          default: begin
            we_n = 1'b1;
            addr_n = row_base + {6'd0, cur_col};
            data_n = in_data;
            col_n = cur_col == COL_MAX ? 7'd0 : cur_col + 7'd1;
            row_n = cur_col != COL_MAX ? cur_row : last_row ? 6'd0 : cur_row + 6'd1;
            row_base_n = cur_col != COL_MAX ? row_base : last_row ? B : row_base + C;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      vmem_addr <= 13'd0;
      vmem_data <= 8'd0;
      vmem_we <= 1'b0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      cur_col <= 7'd0;
      cur_row <= 6'd0;
      clr <= B;
      row_base <= B;
    end else begin
      state <= state_n;
      vmem_addr <= addr_n;
      vmem_data <= data_n;
      vmem_we <= we_n;
      in_ready <= ready_n;
      busy <= busy_n;
      cur_col <= col_n;
      cur_row <= row_n;
      clr <= clr_n;
      row_base <= row_base_n;
    end
  end
endmodule
